// File: rtl/bitgen_parallax_bg.sv
// bitgen_parallax_bg: scaled, frame-locked scrolling, optionally mirrored background layer.
// Defining BITGEN_BG_FADE_EN enables the output fade by fade_level.
module bitgen_parallax_bg #(
  parameter int          BG_WIDTH        = 180,
  parameter int          BG_HEIGHT       = 180,
  parameter logic [16:0] BASE_ADDR       = 17'd5120,
  parameter int          SCALE_X         = 3,
  parameter int          SCALE_Y         = 2,
  parameter int          V_OFFSET        = 60,
  parameter int          ROM_LATENCY     = 1,
  parameter int          FRAMES_PER_STEP = 2,
  parameter logic [7:0]  BG_R            = 8'h88,
  parameter logic [7:0]  BG_G            = 8'hCC,
  parameter logic [7:0]  BG_B            = 8'h88,
  parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        bright,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        dir,
  input  logic [3:0]  scroll_step,
  input  logic        pause,
  input  logic        mirror_en,
  input  logic [1:0]  fade_level,
  input  logic [15:0] bg_data,
  output logic [16:0] bg_addr,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int OW   = (BG_WIDTH > 1) ? $clog2(BG_WIDTH) : 1;
  localparam int SW   = OW + 5;
  localparam int FW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int CW   = 17;
  localparam int VEND = V_OFFSET + BG_HEIGHT * SCALE_Y;
  localparam int HEND = BG_WIDTH * SCALE_X;

  typedef struct packed {
    logic in_band;
    logic bright;
  } ctl_t;

  logic [OW-1:0] scroll_offset;
  logic          flip_phase;
  logic [FW-1:0] frame_cnt;
  logic          frame_tick;
  logic          step_now;

  logic [SW-1:0] off_ext;
  logic [SW-1:0] step_ext;
  logic [SW-1:0] bgw_ext;
  logic [SW-1:0] sum_fwd;
  logic [SW-1:0] nxt_off;
  logic          wrap;

  assign frame_tick = (hcount == 10'd0) && (vcount == 10'd0);
  assign step_now   = frame_tick && !pause &&
                      (frame_cnt == FW'(FRAMES_PER_STEP - 1));

  always_comb begin
    off_ext  = SW'(scroll_offset);
    step_ext = SW'(scroll_step);
    bgw_ext  = SW'(BG_WIDTH);
    sum_fwd  = off_ext + step_ext;
    wrap     = 1'b0;
    nxt_off  = off_ext;
    if (!dir) begin
      wrap    = sum_fwd >= bgw_ext;
      nxt_off = wrap ? sum_fwd - bgw_ext : sum_fwd;
    end else begin
      wrap    = step_ext > off_ext;
      nxt_off = wrap ? off_ext + bgw_ext - step_ext
                     : off_ext - step_ext;
    end
  end

  // Scroll state moves only on frame ticks; pause freezes the divider too.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      scroll_offset <= '0;
      flip_phase    <= 1'b0;
      frame_cnt     <= '0;
    end else if (frame_tick && !pause) begin
      if (step_now) begin
        frame_cnt     <= '0;
        scroll_offset <= OW'(nxt_off);
        if (wrap && mirror_en) begin
          flip_phase <= ~flip_phase;
        end
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic [CW-1:0] h_ext;
  logic [CW-1:0] v_ext;
  logic [CW-1:0] x0;
  logic [CW-1:0] y_img;
  logic [CW-1:0] xs_sum;
  logic [CW-1:0] xs;
  logic [CW-1:0] x_img;
  logic [CW-1:0] lin;
  logic [16:0]   addr_c;
  logic          in_band_c;

  always_comb begin
    h_ext     = CW'(hcount);
    v_ext     = CW'(vcount);
    in_band_c = bright &&
                (v_ext >= CW'(V_OFFSET)) &&
                (v_ext <  CW'(VEND)) &&
                (h_ext <  CW'(HEND));
    x0        = h_ext / CW'(SCALE_X);
    y_img     = (v_ext - CW'(V_OFFSET)) / CW'(SCALE_Y);
    xs_sum    = x0 + CW'(scroll_offset);
    xs        = (xs_sum >= CW'(BG_WIDTH)) ? xs_sum - CW'(BG_WIDTH)
                                          : xs_sum;
    x_img     = flip_phase ? CW'(BG_WIDTH - 1) - xs : xs;
    lin       = y_img * CW'(BG_WIDTH) + x_img;
    addr_c    = in_band_c ? BASE_ADDR + lin : BASE_ADDR;
  end

  ctl_t a_ctl;
  ctl_t dly [ROM_LATENCY];
  ctl_t o_ctl;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      bg_addr <= BASE_ADDR;
      a_ctl   <= '0;
    end else begin
      bg_addr <= addr_c;
      a_ctl   <= '{in_band: in_band_c, bright: bright};
    end
  end

  // Control bits ride alongside the ROM so they meet bg_data in step.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        dly[i] <= '0;
      end
    end else begin
      dly[0] <= a_ctl;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign o_ctl = dly[ROM_LATENCY-1];

  logic [7:0] px_r;
  logic [7:0] px_g;
  logic [7:0] px_b;
  logic       is_key;

  assign is_key = bg_data == TRANSPARENT_KEY;

  always_comb begin
    px_r = 8'h00;
    px_g = 8'h00;
    px_b = 8'h00;
    unique case (1'b1)
      !o_ctl.bright: begin
        px_r = 8'h00;
        px_g = 8'h00;
        px_b = 8'h00;
      end
      o_ctl.bright && (!o_ctl.in_band || is_key): begin
        px_r = BG_R;
        px_g = BG_G;
        px_b = BG_B;
      end
      default: begin
        px_r = {bg_data[15:11], bg_data[15:13]};
        px_g = {bg_data[10:5],  bg_data[10:9]};
        px_b = {bg_data[4:0],   bg_data[4:2]};
      end
    endcase
  end

  logic [7:0] f_r;
  logic [7:0] f_g;
  logic [7:0] f_b;

`ifdef BITGEN_BG_FADE_EN
  assign f_r = px_r >> fade_level;
  assign f_g = px_g >> fade_level;
  assign f_b = px_b >> fade_level;
`else
  logic unused_fade;
  assign unused_fade = ^fade_level;
  assign f_r = px_r;
  assign f_g = px_g;
  assign f_b = px_b;
`endif

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vga_r <= 8'h00;
      vga_g <= 8'h00;
      vga_b <= 8'h00;
    end else begin
      vga_r <= f_r;
      vga_g <= f_g;
      vga_b <= f_b;
    end
  end

endmodule

// File: tb/tb_bitgen_parallax_bg.sv
// tb_bitgen_parallax_bg: scoreboard bench with a behavioural layer model.
// Honours BITGEN_BG_FADE_EN in its model when defined.
module tb_bitgen_parallax_bg;

  localparam int W   = 180;
  localparam int H   = 180;
  localparam int SX  = 3;
  localparam int SY  = 2;
  localparam int VO  = 60;
  localparam int FPS = 2;
  localparam int BASE = 5120;

  logic        pix_clk = 1'b0;
  logic        rst = 1'b1;
  logic        bright = 1'b0;
  logic [9:0]  hcount = 10'd1;
  logic [9:0]  vcount = 10'd1;
  logic        dir = 1'b0;
  logic [3:0]  scroll_step = 4'd0;
  logic        pause = 1'b0;
  logic        mirror_en = 1'b0;
  logic [1:0]  fade_level = 2'd0;
  logic [15:0] bg_data = 16'h0;
  logic [16:0] bg_addr;
  logic [7:0]  vga_r, vga_g, vga_b;

  bitgen_parallax_bg dut (
    .pix_clk(pix_clk), .rst(rst), .bright(bright),
    .hcount(hcount), .vcount(vcount), .dir(dir),
    .scroll_step(scroll_step), .pause(pause),
    .mirror_en(mirror_en), .fade_level(fade_level),
    .bg_data(bg_data), .bg_addr(bg_addr),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 pix_clk = ~pix_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] rom_mem [W*H];

  // Model state and the control values the driver applies.
  int m_off = 0, m_flip = 0, m_fcnt = 0;
  logic c_dir = 0, c_pause = 0, c_mir = 0;
  logic [3:0] c_step = 0;
  logic [1:0] c_fade = 0;

  typedef struct { int due; logic [16:0] addr; } a_exp_t;
  typedef struct { int due; logic [23:0] rgb; } p_exp_t;
  a_exp_t aq[$];
  p_exp_t pq[$];

  always @(posedge pix_clk) begin
    cyc <= cyc + 1;
    if (int'(bg_addr) >= BASE && int'(bg_addr) < BASE + W*H)
      bg_data <= rom_mem[int'(bg_addr) - BASE];
    else
      bg_data <= 16'h0000;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge pix_clk) begin
    #1;
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      chk("bg_addr", 32'(bg_addr), 32'(aq[0].addr));
      void'(aq.pop_front());
    end
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      chk("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(pq[0].rgb));
      void'(pq.pop_front());
    end
  end

  function automatic bit in_img(int h, int v, logic br);
    return br && v >= VO && v < VO + H*SY && h < W*SX;
  endfunction

  function automatic int img_index(int h, int v);
    int x;
    x = ((h / SX) + m_off) % W;
    if (m_flip != 0) x = W - 1 - x;
    return ((v - VO) / SY) * W + x;
  endfunction

  function automatic logic [16:0] model_addr(int h, int v, logic br);
    if (in_img(h, v, br)) return 17'(BASE + img_index(h, v));
    return 17'(BASE);
  endfunction

  function automatic logic [23:0] model_px(int h, int v, logic br);
    logic [15:0] d;
    logic [7:0] r, g, b;
    if (!br) return 24'h0;
    r = 8'h88; g = 8'hCC; b = 8'h88;
    if (in_img(h, v, br)) begin
      d = rom_mem[img_index(h, v)];
      if (d != 16'hF81F) begin
        r = 8'((int'(d[15:11]) * 255 + 15) / 31);
        g = 8'((int'(d[10:5]) * 255 + 31) / 63);
        b = 8'((int'(d[4:0]) * 255 + 15) / 31);
        r = {d[15:11], d[15:13]};
        g = {d[10:5], d[10:9]};
        b = {d[4:0], d[4:2]};
      end
    end
`ifdef BITGEN_BG_FADE_EN
    r = r >> c_fade; g = g >> c_fade; b = b >> c_fade;
`endif
    return {r, g, b};
  endfunction

  task automatic model_tick();
    bit wr;
    if (c_pause) return;
    if (m_fcnt != FPS - 1) begin
      m_fcnt++;
      return;
    end
    m_fcnt = 0;
    if (!c_dir) begin
      wr = (m_off + c_step) >= W;
      m_off = (m_off + c_step) % W;
    end else begin
      wr = c_step > m_off;
      m_off = (m_off - c_step + W) % W;
    end
    if (wr && c_mir) m_flip ^= 1;
  endtask

  task automatic drive(input int h, input int v, input logic br);
    a_exp_t ae;
    p_exp_t pe;
    @(negedge pix_clk);
    hcount = 10'(h); vcount = 10'(v); bright = br;
    dir = c_dir; scroll_step = c_step; pause = c_pause;
    mirror_en = c_mir; fade_level = c_fade;
    ae.due = cyc + 1; ae.addr = model_addr(h, v, br);
    pe.due = cyc + 3; pe.rgb = model_px(h, v, br);
    aq.push_back(ae);
    pq.push_back(pe);
    if (h == 0 && v == 0) model_tick();
  endtask

  task automatic tick_probe();
    drive(0, 0, 1'b1);
    drive(0, VO, 1'b1);
    drive(SX*5 + 1, VO + 7, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge pix_clk);
    rst = 1'b1; bright = 1'b1; hcount = 10'd300; vcount = 10'd200;
    aq.delete();
    pq.delete();
    repeat (3) begin
      @(posedge pix_clk);
      #1;
      chk("reset_addr", 32'(bg_addr), 32'(BASE));
      chk("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    end
    @(negedge pix_clk);
    rst = 1'b0;
    m_off = 0; m_flip = 0; m_fcnt = 0;
  endtask

  task automatic go_offset(input int target);
    int diff;
    c_dir = 0; c_mir = 0; c_pause = 0;
    while (m_off != target) begin
      diff = (target - m_off + W) % W;
      c_step = 4'(diff > 15 ? 15 : diff);
      tick_probe();
      tick_probe();
    end
  endtask

  task automatic drain();
    int waitc = 0;
    while ((aq.size() > 0 || pq.size() > 0) && waitc < 20) begin
      @(posedge pix_clk);
      waitc++;
    end
    if (aq.size() > 0 || pq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0",
               aq.size() + pq.size());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, required test end");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < W*H; i++) begin
      rom_mem[i] = 16'($urandom);
      if ($urandom_range(0, 15) == 0) rom_mem[i] = 16'hF81F;
    end
    rom_mem[0]   = 16'hF81F;
    rom_mem[183] = 16'hF800;

    do_reset();

    // Rate then pause: offset 0,1,1,2,2,3 then held.
    c_dir = 0; c_step = 4'd1; c_mir = 0; c_pause = 0;
    repeat (6) tick_probe();
    c_pause = 1;
    repeat (4) tick_probe();
    c_pause = 0;

    // Forward wrap with mirroring, then reverse wrap without.
    go_offset(178);
    c_step = 4'd5; c_mir = 1;
    tick_probe();
    tick_probe();
    c_dir = 1; c_step = 4'd1; c_mir = 0;
    tick_probe();
    tick_probe();
    c_step = 4'd5;
    tick_probe();
    tick_probe();
    drain();

    // Pipeline, band edges and colour key from a clean state.
    do_reset();
    drive(9, 63, 1'b1);
    drive(0, 10, 1'b1);
    drive(0, VO, 1'b1);
    drive(2, VO, 1'b1);
    drive(W*SX - 1, VO + H*SY - 1, 1'b1);
    drive(W*SX, VO, 1'b1);
    drive(5, VO + H*SY, 1'b1);
    drive(5, VO - 1, 1'b1);
    drive(9, 63, 1'b0);
    drain();
    repeat (4) @(negedge pix_clk);
    c_fade = 2'd1;
    drive(0, 10, 1'b1);
    drive(0, VO, 1'b1);
    drive(9, 63, 1'b1);
    drive(9, 63, 1'b0);
    drain();
    repeat (4) @(negedge pix_clk);
    c_fade = 2'($urandom_range(0, 3));

    // Randomised frames with random scroll controls.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        c_dir = 1'($urandom_range(0, 1));
        c_step = 4'($urandom_range(0, 15));
        c_pause = ($urandom_range(0, 4) == 0);
        c_mir = 1'($urandom_range(0, 1));
        drive(0, 0, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 1) == 0) begin
        drive($urandom_range(0, 639), $urandom_range(VO, VO + H*SY - 1),
              ($urandom_range(0, 7) != 0));
      end else begin
        drive($urandom_range(1, 639), $urandom_range(0, 479),
              ($urandom_range(0, 7) != 0));
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitgen_parallax_bg.md
Name: bitgen_parallax_bg

Overview:
Parametrised successor to the single-image scrolling background generator. Maps VGA (hcount, vcount) to a scaled, horizontally scrolling, optionally mirrored background image in the RGB565 sprite ROM and emits RGB888. Scrolling is frame-locked, with programmable direction, step and rate, and the fetch pipeline is latency-matched to the ROM. Sits between the VGA timing controller and the colour mux, one instance per background layer.

Parameters:
BG_WIDTH, 180, image width in pixels
BG_HEIGHT, 180, image height in pixels
BASE_ADDR, 17'd5120, ROM word address of image pixel (0,0)
SCALE_X, 3, horizontal screen pixels per image pixel (integer ≥1)
SCALE_Y, 2, vertical screen lines per image line (integer ≥1)
V_OFFSET, 60, first screen line of the image band
ROM_LATENCY, 1, pix_clk cycles from bg_addr to valid bg_data (1 or 2)
FRAMES_PER_STEP, 2, frames between scroll updates (≥1)
BG_R/BG_G/BG_B, 8'h88/8'hCC/8'h88, fill colour for transparent or out-of-band pixels
TRANSPARENT_KEY, 16'hF81F, RGB565 colour-key value

Ports:
pix_clk  in  1  pixel clock, sole clock
rst  in  1  synchronous reset, active-high
bright  in  1  active-video flag from the timing controller
hcount  in  10  screen column
vcount  in  10  screen line
dir  in  1  0 = image moves left (offset increments), 1 = offset decrements
scroll_step  in  4  offset change per update, 0..15
pause  in  1  freeze scroll offset and frame divider
mirror_en  in  1  toggle horizontal flip on each wrap
fade_level  in  2  fade amount (BITGEN_BG_FADE_EN only)
bg_data  in  16  RGB565 ROM data
bg_addr  out  17  registered ROM address
vga_r/vga_g/vga_b  out  8 each  registered RGB888

Behaviour:
- Reset (sync, pix_clk edge with rst=1): scroll_offset=0, flip_phase=0, frame_cnt=0, bg_addr=BASE_ADDR, vga_*=0, all pipeline valid/bright bits cleared. Reset overrides any in-flight pipeline data.
- Frame tick: one-cycle strobe when hcount==0 && vcount==0.
- On a frame tick with pause=0: if frame_cnt==FRAMES_PER_STEP-1, then frame_cnt←0 and apply a step; otherwise frame_cnt increments. pause=1 holds both frame_cnt and the offset.
- Step, dir=0: s=offset+scroll_step. If s≥BG_WIDTH, offset←s-BG_WIDTH and a wrap occurs; otherwise offset←s.
- Step, dir=1: if scroll_step>offset, offset←offset+BG_WIDTH-scroll_step and a wrap occurs; otherwise offset←offset-scroll_step.
- On a wrap with mirror_en=1, flip_phase toggles. With mirror_en=0, flip_phase is held.
- scroll_step=0 never wraps. scroll_step<BG_WIDTH is guaranteed by the integrator.
- Offset is always in 0..BG_WIDTH-1. Offset and flip changes affect only pixels whose address is computed after the tick.
- Stage A (registered):
  - in_band = bright && V_OFFSET ≤ vcount < V_OFFSET+BG_HEIGHT*SCALE_Y && hcount < BG_WIDTH*SCALE_X.
  - x0=hcount/SCALE_X, y=(vcount-V_OFFSET)/SCALE_Y.
  - xs=(x0+offset) mod BG_WIDTH; x = flip_phase ? BG_WIDTH-1-xs : xs.
  - bg_addr←BASE_ADDR+y*BG_WIDTH+x when in_band, else BASE_ADDR.
  - Division may be dividers or incremental counters, but results must be bit-exact.
- in_band and bright are delayed ROM_LATENCY cycles to align with bg_data.
- Output stage (registered):
  - !bright → vga_*=0.
  - bright && (!in_band || bg_data==TRANSPARENT_KEY) → BG_R/G/B.
  - Otherwise expand RGB565: r={r5,r5[4:2]}, g={g6,g6[5:4]}, b={b5,b5[4:2]}.
- Total latency from hcount/vcount to vga_* is ROM_LATENCY+2 cycles. The timing controller delays hsync/vsync to match.

Optional Feature:
BITGEN_BG_FADE_EN. When defined, the output stage right-shifts each 8-bit channel by fade_level (0..3), including the fill colour; blanking stays 0. Latency is unchanged. When undefined, fade_level is ignored and output is unfaded; the port remains present.

Test Plan:
- Reset: rst=1 for 3 cycles, mid-frame, with bright=1 → bg_addr=5120, vga_*=0. Offset is 0 after release.
- Rate: FRAMES_PER_STEP=2, step=1, dir=0, 6 frame ticks → offset 0→0→1→1→2→2→3. With pause=1 over 4 ticks, offset is held.
- Forward wrap: offset=178, step=5, mirror_en=1 → offset=3, flip_phase=1. Next pixel at hcount=0, vcount=60 → bg_addr=5120+179-3=5296.
- Reverse wrap: dir=1, offset=2, step=5 → offset=177. With mirror_en=0, flip is unchanged.
- Pipeline: ROM_LATENCY=1, offset=0, hcount=9, vcount=63 → bg_addr=5120+1*180+3=5303 one cycle later. bg_data=16'hF800 → vga=FF/00/00 exactly 3 cycles after the input.
- Band and key: vcount=10, bright=1 → 88/CC/88. In band with bg_data=F81F → 88/CC/88. With FADE_EN and fade_level=1 → 44/66/44.
